// File: rtl/booth_mult_param.sv
// Parametrised sequential radix-2 Booth multiplier with HI/LO result registers.
// Operands are widened by one bit (sign or zero), so a single signed Booth
// engine covers both signed and unsigned products. Latency is WIDTH+2 edges
// from the start edge to the edge that updates hi/lo and raises done.
module booth_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] outA,
    input  logic [WIDTH-1:0] outB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Extended operand width, product register width and step counter width.
    // The counter must hold the value E itself, hence clog2(E+1).
    localparam int E  = WIDTH + 1;
    localparam int PW = 2 * E + 1;
    localparam int CW = $clog2(E + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t          state;
    logic [PW-1:0]   p_reg;
    logic [E-1:0]    m_reg;
    logic [E-1:0]    neg_m;
    logic [CW-1:0]   count;

    logic [E-1:0]    ext_a;
    logic [E-1:0]    ext_b;
    logic [E-1:0]    upper;
    logic [E-1:0]    booth_sum;
    logic [PW-1:0]   p_shifted;

    // The top operand bit is replicated only in signed mode; unsigned operands
    // get a zero on top so they read as non-negative to the signed engine.
    assign ext_a = {is_signed & outA[WIDTH-1], outA};
    assign ext_b = {is_signed & outB[WIDTH-1], outB};

    // The accumulating half of the product register.
    assign upper = p_reg[PW-1:E+1];

    // One Booth step: pick the addend from the current/previous multiplier
    // bit pair, add modulo 2^E, then arithmetic-shift the whole register.
    always_comb begin
        booth_sum = upper;
        case (p_reg[1:0])
            2'b01:   booth_sum = upper + m_reg;
            2'b10:   booth_sum = upper + neg_m;
            default: booth_sum = upper;
        endcase
        p_shifted = {booth_sum[E-1], booth_sum, p_reg[E:1]};
    end

    // Control FSM with datapath registers; hi/lo change only at FINISH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            p_reg <= '0;
            m_reg <= '0;
            neg_m <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        p_reg <= {{E{1'b0}}, ext_b, 1'b0};
                        m_reg <= ext_a;
                        neg_m <= (~ext_a) + {{(E-1){1'b0}}, 1'b1};
                        count <= CW'(E);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p_reg <= p_shifted;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    hi    <= p_reg[2*WIDTH:WIDTH+1];
                    lo    <= p_reg[WIDTH:1];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_param.sv
// Directed bench for booth_mult_param at WIDTH=32 and WIDTH=8, with a short
// run of random operand pairs checked against a wide-multiply reference.
module tb_booth_mult_param;

    logic        clock;
    logic        reset;

    logic        start32, sgn32;
    logic [31:0] a32, b32;
    logic        busy32, done32;
    logic [31:0] hi32, lo32;

    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int checks;
    int failures;

    booth_mult_param #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .is_signed(sgn32),
        .outA(a32), .outB(b32), .busy(busy32), .done(done32),
        .hi(hi32), .lo(lo32)
    );

    booth_mult_param #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_signed(sgn8),
        .outA(a8), .outB(b8), .busy(busy8), .done(done8),
        .hi(hi8), .lo(lo8)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents a one-cycle start; returns 1ns after the start edge (edge 0),
    // with the operands scrambled to show they are not re-sampled.
    task automatic applyStimulus32(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(posedge clock); #1;
        start32 = 1'b1; sgn32 = s; a32 = a; b32 = b;
        @(posedge clock); #1;
        start32 = 1'b0; sgn32 = ~s; a32 = ~a; b32 = b ^ 32'h5A5A_5A5A;
    endtask

    task automatic applyStimulus8(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(posedge clock); #1;
        start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
        @(posedge clock); #1;
        start8 = 1'b0; sgn8 = ~s; a8 = ~a; b8 = b ^ 8'h5A;
    endtask

    // Full operation at WIDTH=32: done must be low at edge 33, high at edge 34.
    task automatic runOp32(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        applyStimulus32(s, a, b);
        checkOutput({tag, "_busy"}, 64'(busy32), 64'd1);
        repeat (33) @(posedge clock);
        #1;
        checkOutput({tag, "_early_done"}, 64'(done32), 64'd0);
        @(posedge clock); #1;
        checkOutput({tag, "_done"}, 64'(done32), 64'd1);
        checkOutput({tag, "_busy_low"}, 64'(busy32), 64'd0);
        checkOutput({tag, "_hi"}, 64'(hi32), 64'(eh));
        checkOutput({tag, "_lo"}, 64'(lo32), 64'(el));
    endtask

    // Full operation at WIDTH=8: done must be low at edge 9, high at edge 10.
    task automatic runOp8(input string tag, input logic s, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] eh, input logic [7:0] el);
        applyStimulus8(s, a, b);
        repeat (9) @(posedge clock);
        #1;
        checkOutput({tag, "_early_done"}, 64'(done8), 64'd0);
        @(posedge clock); #1;
        checkOutput({tag, "_done"}, 64'(done8), 64'd1);
        checkOutput({tag, "_hi"}, 64'(hi8), 64'(eh));
        checkOutput({tag, "_lo"}, 64'(lo8), 64'(el));
    endtask

    initial begin
        logic [31:0]        ra, rb;
        logic               rs;
        logic signed [65:0] ea, eb, prod;
        logic signed [17:0] ea8, eb8, prod8;

        checks = 0;
        failures = 0;
        start32 = 0; sgn32 = 0; a32 = '0; b32 = '0;
        start8  = 0; sgn8  = 0; a8  = '0; b8  = '0;

        // Reset state
        reset = 1'b1;
        #1 reset = 1'b0;
        #3;
        checkOutput("rst_busy", 64'(busy32), 64'd0);
        checkOutput("rst_done", 64'(done32), 64'd0);
        checkOutput("rst_hilo", {hi32, lo32}, 64'd0);
        checkOutput("rst_hilo8", 64'({hi8, lo8}), 64'd0);
        #18 reset = 1'b1;

        // Signed small: 7 * -3 = -21
        runOp32("s7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        @(posedge clock); #1;
        checkOutput("s7xm3_done_pulse", 64'(done32), 64'd0);

        // Mode split on all-ones operands
        runOp32("u_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        runOp32("s_ff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

        // Most-negative squared, and zero multiplicand
        runOp32("s_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        runOp32("zero", 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);

        // Starts at cycles 5 and 20 of an unsigned 0xFFFFFFFF*2 are ignored
        applyStimulus32(1'b0, 32'hFFFF_FFFF, 32'd2);
        repeat (4) @(posedge clock);
        #1;
        start32 = 1'b1; sgn32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h1111_1111;
        @(posedge clock); #1;
        start32 = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        start32 = 1'b1;
        @(posedge clock); #1;
        start32 = 1'b0;
        repeat (13) @(posedge clock);
        #1;
        checkOutput("ign_early_done", 64'(done32), 64'd0);
        @(posedge clock); #1;
        checkOutput("ign_done", 64'(done32), 64'd1);
        checkOutput("ign_hilo", {hi32, lo32}, 64'h0000_0001_FFFF_FFFE);
        @(posedge clock); #1;
        checkOutput("ign_no_queue", 64'(busy32), 64'd0);

        // Back-to-back: second start presented in the done cycle
        runOp32("b2b_a", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        start32 = 1'b1; sgn32 = 1'b0; a32 = 32'h0001_0000; b32 = 32'h0001_0000;
        @(posedge clock); #1;
        start32 = 1'b0; a32 = '0; b32 = '0;
        checkOutput("b2b_busy", 64'(busy32), 64'd1);
        checkOutput("b2b_hold_hi", 64'(hi32), 64'hFFFF_FFFF);
        repeat (33) @(posedge clock);
        #1;
        checkOutput("b2b_early_done", 64'(done32), 64'd0);
        checkOutput("b2b_hold_lo", 64'(lo32), 64'hFFFF_FFFE);
        @(posedge clock); #1;
        checkOutput("b2b_done", 64'(done32), 64'd1);
        checkOutput("b2b_hilo", {hi32, lo32}, 64'h0000_0001_0000_0000);

        // Asynchronous reset mid-operation, then a fresh 3*4
        applyStimulus32(1'b0, 32'd5, 32'd6);
        repeat (10) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 64'(busy32), 64'd0);
        checkOutput("mid_rst_done", 64'(done32), 64'd0);
        checkOutput("mid_rst_hilo", {hi32, lo32}, 64'd0);
        #2 reset = 1'b1;
        runOp32("post_rst", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);

        // WIDTH=8 directed vectors
        runOp8("w8_min", 1'b1, 8'h80, 8'h80, 8'h40, 8'h00);
        runOp8("w8_uff", 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        runOp8("w8_sff", 1'b1, 8'hFF, 8'hFF, 8'h00, 8'h01);
        runOp8("w8_mix", 1'b1, 8'h7F, 8'h80, 8'hC0, 8'h80);
        runOp8("w8_u80", 1'b0, 8'h80, 8'h02, 8'h01, 8'h00);

        // Random pairs against a wide signed-multiply reference
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            ea = rs ? {{34{ra[31]}}, ra} : {34'd0, ra};
            eb = rs ? {{34{rb[31]}}, rb} : {34'd0, rb};
            prod = ea * eb;
            runOp32("rnd32", rs, ra, rb, prod[63:32], prod[31:0]);
        end
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            ea8 = rs ? {{10{ra[7]}}, ra[7:0]} : {10'd0, ra[7:0]};
            eb8 = rs ? {{10{rb[7]}}, rb[7:0]} : {10'd0, rb[7:0]};
            prod8 = ea8 * eb8;
            runOp8("rnd8", rs, ra[7:0], rb[7:0], prod8[15:8], prod8[7:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
